// File: rtl/ifm_pkg.sv
// ifm_pkg: shared types for the instruction fetch memory.
//   state_t       - load/run controller states (RUN, DRAIN, LOAD)
//   patch_entry_t - one patch-table entry {valid, addr, word}; the address
//                   and word fields are sized to the widest supported
//                   configuration and zero-extended by the users
//   patch_base()  - first address of the patch-select window (top NPATCH
//                   addresses of the AW-bit load address space)
package ifm_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    LOAD  = 2'd2
  } state_t;

  localparam int PATCH_AW_MAX = 16;
  localparam int PATCH_IW_MAX = 32;

  typedef struct packed {
    logic                    valid;
    logic [PATCH_AW_MAX-1:0] addr;
    logic [PATCH_IW_MAX-1:0] word;
  } patch_entry_t;

  function automatic int patch_base(input int aw, input int npatch);
    return (1 << aw) - npatch;
  endfunction

  // Window base for the default geometry (AW=10, NPATCH=2).
  localparam int PATCH_BASE_DEFAULT = patch_base(10, 2);

endpackage

// File: rtl/inst_fetch_mem_if.sv
// inst_fetch_mem_if: fetch request/response channels plus program-load port.
//   master modport: fetch unit / loader side (drives requests, load strobes)
//   slave  modport: instruction memory side
//
// Handshake: a transfer happens on a rising clock edge where valid && ready.
// A producer holding valid high keeps its payload stable until that edge;
// ready may depend combinationally on the consumer state but never on the
// payload. The request channel uses req_valid/req_ready, the response
// channel resp_valid/resp_ready.
interface inst_fetch_mem_if #(
  parameter int IW = 9,
  parameter int AW = 10
);
  logic          req_valid;
  logic [AW-1:0] req_addr;
  logic          req_ready;
  logic          resp_valid;
  logic [IW-1:0] resp_inst;
  logic          resp_oor;
  logic          resp_ready;
  logic          ld_start;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic [IW-1:0] ld_data;
  logic          ld_done;
  logic          loading;

  modport master (
    output req_valid, req_addr, resp_ready,
    output ld_start, ld_valid, ld_addr, ld_data, ld_done,
    input  req_ready, resp_valid, resp_inst, resp_oor, loading
  );

  modport slave (
    input  req_valid, req_addr, resp_ready,
    input  ld_start, ld_valid, ld_addr, ld_data, ld_done,
    output req_ready, resp_valid, resp_inst, resp_oor, loading
  );
endinterface

// File: rtl/ifm_patch_table.sv
// ifm_patch_table: NPATCH-entry address-match table that overrides fetches.
//   clk, rst_n  - clock, asynchronous active-low reset (entries -> invalid)
//   wr_en       - load strobe while the controller is in LOAD
//   wr_addr     - load address; ~wr_addr selects entry k inside the window
//   wr_data     - load data
//   rd_addr     - fetch address to look up
//   hit         - some valid entry matches rd_addr
//   hit_word    - word of the lowest-index matching entry
// An entry takes two strobes to its window address: the first sets the
// match address (wr_data zero-extended) and invalidates the entry, the
// second sets the word and marks the entry valid. The window must lie at or
// above DEPTH so it never aliases the instruction array.
module ifm_patch_table
  import ifm_pkg::*;
#(
  parameter int AW     = 10,
  parameter int IW     = 9,
  parameter int NPATCH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [IW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic          hit,
  output logic [IW-1:0] hit_word
);

  patch_entry_t      entry_q [NPATCH];
  logic [NPATCH-1:0] phase_q;  // 1: next strobe to this entry writes its word
  logic [AW-1:0]     slot;

  // all-ones minus address is the bitwise inverse
  assign slot = ~wr_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NPATCH; k++) entry_q[k] <= '0;
      phase_q <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < NPATCH; k++) begin
        if (slot == AW'(k)) begin
          if (!phase_q[k]) begin
            entry_q[k].valid <= 1'b0;
            entry_q[k].addr  <= PATCH_AW_MAX'(wr_data);
            phase_q[k]       <= 1'b1;
          end else begin
            entry_q[k].valid <= 1'b1;
            entry_q[k].word  <= PATCH_IW_MAX'(wr_data);
            phase_q[k]       <= 1'b0;
          end
        end
      end
    end
  end

  // Walk from the top so the lowest matching index is the last assignment.
  always_comb begin
    hit      = 1'b0;
    hit_word = '0;
    for (int k = NPATCH - 1; k >= 0; k--) begin
      if (entry_q[k].valid && (entry_q[k].addr == PATCH_AW_MAX'(rd_addr))) begin
        hit      = 1'b1;
        hit_word = entry_q[k].word[IW-1:0];
      end
    end
  end

  // Upper word bits are always zero; fold them so they count as consumed.
  logic word_unused;
  always_comb begin
    word_unused = 1'b0;
    for (int k = 0; k < NPATCH; k++)
      word_unused = word_unused ^ (^entry_q[k].word[PATCH_IW_MAX-1:IW]);
  end

endmodule

// File: rtl/inst_fetch_mem.sv
// inst_fetch_mem: instruction memory for the fetch stage.
//   CLK    - clock
//   rst_n  - asynchronous active-low reset
//   bus    - inst_fetch_mem_if slave: fetch request/response + load port
//   state  - current controller state (RUN / DRAIN / LOAD) for observation
// Reads are registered (one-cycle latency). Addresses >= DEPTH return
// NOP_WORD with resp_oor set. ld_start moves to LOAD (through DRAIN when a
// stalled response is outstanding); fetch is blocked outside RUN so loads
// never collide with reads. The array is not reset.
// Optional build macro: INST_PATCH_EN adds ifm_patch_table, whose hits
// override both the array and the range check.
module inst_fetch_mem
  import ifm_pkg::*;
#(
  parameter int            IW        = 9,
  parameter int            AW        = 10,
  parameter int            DEPTH     = 256,
  parameter logic [IW-1:0] NOP_WORD  = '0,
  parameter string         INIT_FILE = "instructions.txt",
  parameter int            NPATCH    = 2
) (
  input  logic            CLK,
  input  logic            rst_n,
  inst_fetch_mem_if.slave bus,
  output state_t          state
);

  localparam int            IDXW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   DEPTH_EXT = (AW+1)'(DEPTH);

  logic [IW-1:0] mem [DEPTH];

  state_t        state_q, state_d;
  logic          resp_valid_q, resp_oor_q;
  logic [IW-1:0] resp_inst_q;
  logic          accept, req_in_range, ld_in_range, load_wr;
  logic [IW-1:0] rd_word;
  logic          rd_oor;

  // ---------------- controller ----------------
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      // ld_start outranks ld_done here; a stalled response must drain first
      RUN:     if (bus.ld_start) state_d = (resp_valid_q && !bus.resp_ready) ? DRAIN : LOAD;
      DRAIN:   if (bus.resp_ready) state_d = LOAD;
      LOAD:    if (bus.ld_done) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  assign state       = state_q;
  assign bus.loading = (state_q != RUN);

  // ---------------- fetch path ----------------
  assign bus.req_ready = (state_q == RUN) && (!resp_valid_q || bus.resp_ready);
  assign accept        = bus.req_valid && bus.req_ready;
  assign req_in_range  = ({1'b0, bus.req_addr} < DEPTH_EXT);

`ifdef INST_PATCH_EN
  logic          patch_hit;
  logic [IW-1:0] patch_word;

  ifm_patch_table #(
    .AW     (AW),
    .IW     (IW),
    .NPATCH (NPATCH)
  ) u_patch (
    .clk      (CLK),
    .rst_n    (rst_n),
    .wr_en    (load_wr),
    .wr_addr  (bus.ld_addr),
    .wr_data  (bus.ld_data),
    .rd_addr  (bus.req_addr),
    .hit      (patch_hit),
    .hit_word (patch_word)
  );
`else
  localparam int unused_npatch = NPATCH;
`endif

  always_comb begin
    rd_word = NOP_WORD;
    rd_oor  = 1'b1;
    if (req_in_range) begin
      rd_word = mem[bus.req_addr[IDXW-1:0]];
      rd_oor  = 1'b0;
    end
`ifdef INST_PATCH_EN
    if (patch_hit) begin
      rd_word = patch_word;
      rd_oor  = 1'b0;
    end
`endif
  end

  // Response register: loads on accept, holds while stalled, clears after
  // a handshake that is not refilled by a new accept.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= 1'b0;
      resp_inst_q  <= NOP_WORD;
      resp_oor_q   <= 1'b0;
    end else if (accept) begin
      resp_valid_q <= 1'b1;
      resp_inst_q  <= rd_word;
      resp_oor_q   <= rd_oor;
    end else if (bus.resp_ready) begin
      resp_valid_q <= 1'b0;
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_inst  = resp_inst_q;
  assign bus.resp_oor   = resp_oor_q;

  // ---------------- load path ----------------
  assign load_wr     = (state_q == LOAD) && bus.ld_valid;
  assign ld_in_range = ({1'b0, bus.ld_addr} < DEPTH_EXT);

  // Out-of-range writes (including the patch window) never touch the array.
  always_ff @(posedge CLK) begin
    if (load_wr && ld_in_range) mem[bus.ld_addr[IDXW-1:0]] <= bus.ld_data;
  end

endmodule
